// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load-type/size constants, memory-unit state type and byte-enable helper
package riscv_pkg;
  localparam logic [2:0] LT_B = 3'd0, LT_H = 3'd1, LT_W = 3'd2, LT_BU = 3'd3, LT_HU = 3'd4;
  localparam logic [1:0] MB_B = 2'd0, MB_H = 2'd1, MB_W = 2'd2;
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} mem_state_t;
  function automatic logic [3:0] byte_en(input logic [1:0] by, input logic [1:0] off);
    return by[1] ? 4'b1111 : by[0] ? 4'b0011 << off : 4'b0001 << off;
  endfunction
endpackage

// File: rtl/riscv_mem_if_if.sv
// riscv_mem_if_if: word-wide memory bus with variable-latency ready handshake
interface riscv_mem_if_if #(parameter int AW = 32);
  logic bus_req, bus_we, bus_ready;
  logic [AW-3:0] bus_addr;
  logic [3:0] bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ready, bus_rdata);
  modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ready, bus_rdata);
endinterface

// File: rtl/riscv_mem_if_load_ext.sv
// riscv_load_ext: extracts a byte/half/word from a bus word and sign- or zero-extends it
module riscv_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  lt,
  output logic [31:0] result
);
  logic [31:0] s;
  assign s = bus_rdata >> {off, 3'b000};
  assign result = lt == LT_B  ? {{24{s[7]}}, s[7:0]} :
                  lt == LT_H  ? {{16{s[15]}}, s[15:0]} :
                  lt == LT_W  ? s :
                  lt == LT_BU ? {24'd0, s[7:0]} : {16'd0, s[15:0]};
endmodule

// File: rtl/riscv_mem_if.sv
// riscv_mem_if: turns control-unit read/write strobes into single byte-lane bus transactions
module riscv_mem_if
  import riscv_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_RE,
  input  logic          mem_WE,
  input  logic [1:0]    mem_by,
  input  logic [2:0]    sel_b_h_w_bu_hu,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          done,
  output logic          misalign,
  riscv_mem_if_if.master bus
);
  mem_state_t state;
  logic [1:0] off;
  logic [2:0] lt;
  logic [31:0] ext, wd;
  logic mis;
  riscv_load_ext u_ext (.bus_rdata(bus.bus_rdata), .off(off), .lt(lt), .result(ext));
  assign mis = mem_by[1] ? |addr[1:0] : mem_by[0] & addr[0];
  assign wd = mem_by[1] ? wdata : mem_by[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  // HOLD absorbs a request level that outlives its transaction so it never reissues
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      misalign <= 1'b0;
      off <= '0;
      lt <= '0;
      bus.bus_req <= 1'b0;
      bus.bus_we <= 1'b0;
      bus.bus_addr <= '0;
      bus.bus_be <= '0;
      bus.bus_wdata <= '0;
    end else begin
      done <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: if (mem_WE || mem_RE) begin
          bus.bus_we <= mem_WE;
          bus.bus_addr <= addr[AW-1:2];
          bus.bus_be <= byte_en(mem_by, addr[1:0]);
          bus.bus_wdata <= wd;
          off <= addr[1:0];
          lt <= sel_b_h_w_bu_hu;
          busy <= 1'b1;
          done <= mis;
          misalign <= mis;
          bus.bus_req <= !mis;
          state <= mis ? HOLD : ACCESS;
        end
        ACCESS: if (bus.bus_ready) begin
          bus.bus_req <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          if (!bus.bus_we) rdata <= ext;
          state <= HOLD;
        end
        HOLD: begin
          busy <= 1'b0;
          if (!mem_RE && !mem_WE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_riscv_mem_if.sv
// tb_riscv_mem_if: directed vectors with hand-computed expectations for riscv_mem_if
module tb_riscv_mem_if;
  import riscv_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, mem_RE = 1'b0, mem_WE = 1'b0;
  logic [1:0] mem_by = '0;
  logic [2:0] sel = '0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic busy, done, misalign;
  int n_chk = 0, n_err = 0;
  int n_req, n_done, n_busy, n_mis, t_done;
  logic [31:0] f_addr, f_be, f_wd, f_we;
  riscv_mem_if_if #(.AW(32)) bif ();
  riscv_mem_if #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_by(mem_by),
    .sel_b_h_w_bu_hu(sel), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .done(done), .misalign(misalign), .bus(bif.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // lat = number of cycles bus_req stays high before the memory answers
  task automatic run(input logic we, input logic [1:0] by, input logic [2:0] lt,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int lat);
    n_req = 0; n_done = 0; n_busy = 0; n_mis = 0; t_done = 0;
    f_addr = '0; f_be = '0; f_wd = '0; f_we = '0;
    mem_WE = we; mem_RE = !we; mem_by = by; sel = lt; addr = a; wdata = wd;
    bif.bus_rdata = rd; bif.bus_ready = 1'b1;
    for (int c = 1; c <= 12 && n_done == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (bif.bus_req) begin
        if (n_req == 0) begin
          f_addr = 32'(bif.bus_addr); f_be = 32'(bif.bus_be); f_wd = bif.bus_wdata; f_we = 32'(bif.bus_we);
        end
        n_req++;
        bif.bus_ready = n_req >= lat;
      end
      n_busy += int'(busy);
      n_mis += int'(misalign);
      if (done) begin n_done++; t_done = c; end
    end
    mem_WE = 1'b0; mem_RE = 1'b0; bif.bus_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    n_done += int'(done);
    n_req += int'(bif.bus_req);
  endtask
  initial begin
    bif.bus_ready = 1'b0; bif.bus_rdata = '0;
    #12;
    check("rst_req", 32'(bif.bus_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_mis", 32'({done, misalign}), 0);
    check("rst_rdata", rdata, 0);
    check("rst_fields", {bif.bus_addr[27:0], bif.bus_be}, 0);
    check("rst_wd_we", bif.bus_wdata | 32'(bif.bus_we), 0);
    @(negedge clk); rst_n = 1'b1;
    run(1'b1, MB_B, LT_B, 32'h103, 32'hA5, 32'h0, 1);
    check("sb_addr", f_addr, 32'h40);
    check("sb_be", f_be, 32'h8);
    check("sb_wdata", f_wd, 32'hA5A5A5A5);
    check("sb_we", f_we, 1);
    check("sb_latency", 32'(t_done), 2);
    check("sb_done", 32'(n_done), 1);
    run(1'b1, MB_H, LT_H, 32'h2, 32'hFFFF1234, 32'h0, 1);
    check("sh_be", f_be, 32'hC);
    check("sh_wdata", f_wd, 32'h12341234);
    run(1'b0, MB_B, LT_B, 32'h102, 32'h0, 32'h12F45678, 1);
    check("lb_rdata", rdata, 32'hFFFFFFF4);
    check("lb_be", f_be, 32'h4);
    check("lb_we", f_we, 0);
    run(1'b0, MB_B, LT_BU, 32'h102, 32'h0, 32'h12F45678, 1);
    check("lbu_rdata", rdata, 32'h000000F4);
    run(1'b0, MB_H, LT_HU, 32'h200, 32'h0, 32'h80018765, 1);
    check("lhu_rdata", rdata, 32'h00008765);
    run(1'b0, MB_H, LT_H, 32'h202, 32'h0, 32'h80010000, 3);
    check("lh_rdata", rdata, 32'hFFFF8001);
    check("lh_req_cycles", 32'(n_req), 3);
    check("lh_busy_cycles", 32'(n_busy), 3);
    check("lh_done", 32'(n_done), 1);
    check("lh_addr", f_addr, 32'h80);
    run(1'b0, MB_W, LT_W, 32'h101, 32'h0, 32'hDEADBEEF, 1);
    check("mis_req", 32'(n_req), 0);
    check("mis_pulse", 32'(n_mis), 1);
    check("mis_done", 32'(n_done), 1);
    check("mis_latency", 32'(t_done), 1);
    check("mis_busy", 32'(n_busy), 1);
    check("mis_rdata", rdata, 32'hFFFF8001);
    run(1'b0, MB_H, LT_H, 32'h5, 32'h0, 32'h0, 1);
    check("mish_pulse", 32'(n_mis), 1);
    check("mish_req", 32'(n_req), 0);
    @(negedge clk);
    mem_RE = 1'b1; mem_by = MB_W; sel = LT_W; addr = 32'h10;
    bif.bus_rdata = 32'h11223344; bif.bus_ready = 1'b1;
    n_req = 0; n_done = 0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      n_req += int'(bif.bus_req);
      n_done += int'(done);
    end
    check("held_req", 32'(n_req), 1);
    check("held_done", 32'(n_done), 1);
    check("held_rdata", rdata, 32'h11223344);
    check("held_busy", 32'(busy), 0);
    mem_RE = 1'b0;
    @(posedge clk); @(negedge clk);
    run(1'b0, MB_W, LT_W, 32'h14, 32'h0, 32'h55667788, 1);
    check("after_held_rdata", rdata, 32'h55667788);
    check("after_held_lat", 32'(t_done), 2);
    @(negedge clk);
    mem_RE = 1'b1; mem_by = MB_W; sel = LT_W; addr = 32'h300; bif.bus_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_req", 32'(bif.bus_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bif.bus_req), 0);
    check("async_rst_busy", 32'(busy), 0);
    mem_RE = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_done", 32'(done), 0);
    check("post_rst_rdata", rdata, 0);
    run(1'b0, MB_W, LT_W, 32'h0, 32'h0, 32'hCAFEBABE, 2);
    check("post_rst_lw", rdata, 32'hCAFEBABE);
    check("post_rst_lw_done", 32'(n_done), 1);
    check("post_rst_lw_addr", f_addr, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
